// File: rtl/adc_scan_if.sv
// Shared power-monitor ADC handshake: convert request/channel out, result strobe/value back.
// The scheduler takes the master side, the ADC front end the slave side.
interface adc_scan_if #(
    parameter int CH_W   = 2,
    parameter int DATA_W = 16
);
    logic              adc_start;
    logic [CH_W-1:0]   adc_ch;
    logic              adc_data_valid;
    logic [DATA_W-1:0] adc_data_value;

    modport master (
        output adc_start,
        output adc_ch,
        input  adc_data_valid,
        input  adc_data_value
    );

    modport slave (
        input  adc_start,
        input  adc_ch,
        output adc_data_valid,
        output adc_data_value
    );
endinterface

// File: rtl/adc_scan_scheduler.sv
// Scans enabled current-sense channels through one shared ADC at a fixed start-to-start
// interval, with a per-conversion timeout and one-hot per-channel result strobes.
module adc_scan_scheduler #(
    parameter int NUM_CH      = 4,
    parameter int CH_W        = 2,
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = 1024,
    parameter int TMO_W       = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [NUM_CH-1:0] ch_enable_mask,
    input  logic [15:0]       scan_interval,
    adc_scan_if.master        adc,
    output logic [NUM_CH-1:0] ch_data_valid,
    output logic [DATA_W-1:0] ch_data_value,
    output logic              scan_done,
    output logic              adc_timeout_fail,
    input  logic              clear_timeout_fail
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_IVL = 3'd1,
        START    = 3'd2,
        CONVERT  = 3'd3,
        NEXT     = 3'd4,
        FAULT    = 3'd5
    } state_t;

    state_t            state_reg, state_next;
    logic [NUM_CH-1:0] mask_reg, mask_next;
    logic [CH_W-1:0]   ch_reg, ch_next;
    logic [15:0]       ivl_cnt_reg;
    logic [TMO_W-1:0]  tmo_cnt_reg;
    logic [DATA_W-1:0] data_reg;
    logic [NUM_CH-1:0] ch_valid_reg;
    logic              done_reg;
    logic              fail_reg;

    logic              ivl_load;
    logic              capture;
    logic              done_set;
    logic              fail_set;
    logic              fail_clr;
    logic [NUM_CH-1:0] above_mask;
    logic [NUM_CH-1:0] ch_onehot;

    // Lowest set bit wins; scanning downward lets the last assignment be the lowest.
    function automatic logic [CH_W-1:0] lowest_set(input logic [NUM_CH-1:0] v);
        logic [CH_W-1:0] idx;
        idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (v[i]) idx = CH_W'(i);
        end
        return idx;
    endfunction

    // Channels of the snapshot still pending in this scan, and the decode of the current one.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign above_mask[gi] = mask_reg[gi] && (CH_W'(gi) > ch_reg);
        assign ch_onehot[gi]  = (ch_reg == CH_W'(gi));
    end

    always_comb begin
        state_next = state_reg;
        mask_next  = mask_reg;
        ch_next    = ch_reg;
        ivl_load   = 1'b0;
        capture    = 1'b0;
        done_set   = 1'b0;
        fail_set   = 1'b0;
        fail_clr   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (enable && (|ch_enable_mask)) begin
                    mask_next  = ch_enable_mask;
                    ch_next    = lowest_set(ch_enable_mask);
                    ivl_load   = 1'b1;
                    state_next = START;
                end
            end
            WAIT_IVL: begin
                if (!enable) begin
                    state_next = IDLE;
                end else if (ivl_cnt_reg < 16'd2) begin
                    // Counter was loaded one cycle before the previous START, so 1 means
                    // the next START lands exactly scan_interval cycles after it.
                    if (|ch_enable_mask) begin
                        mask_next  = ch_enable_mask;
                        ch_next    = lowest_set(ch_enable_mask);
                        ivl_load   = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            START: begin
                state_next = CONVERT;
            end
            CONVERT: begin
                if (adc.adc_data_valid) begin
                    capture    = 1'b1;
                    state_next = NEXT;
                end else if (tmo_cnt_reg == TMO_W'(TIMEOUT_CYC - 1)) begin
                    fail_set   = 1'b1;
                    state_next = FAULT;
                end
            end
            NEXT: begin
                if (!enable) begin
                    state_next = IDLE;
                end else if (|above_mask) begin
                    ch_next    = lowest_set(above_mask);
                    state_next = START;
                end else begin
                    done_set   = 1'b1;
                    state_next = WAIT_IVL;
                end
            end
            FAULT: begin
                if (clear_timeout_fail) begin
                    fail_clr   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            mask_reg     <= '0;
            ch_reg       <= '0;
            ivl_cnt_reg  <= '0;
            tmo_cnt_reg  <= '0;
            data_reg     <= '0;
            ch_valid_reg <= '0;
            done_reg     <= 1'b0;
            fail_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            mask_reg  <= mask_next;
            ch_reg    <= ch_next;

            // Interval runs free from scan start so long scans simply eat into the wait.
            if (ivl_load) begin
                ivl_cnt_reg <= scan_interval;
            end else if (ivl_cnt_reg != 16'd0) begin
                ivl_cnt_reg <= ivl_cnt_reg - 16'd1;
            end

            if (state_reg == START) begin
                tmo_cnt_reg <= '0;
            end else if (state_reg == CONVERT) begin
                tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
            end

            if (capture) begin
                data_reg <= adc.adc_data_value;
            end
            ch_valid_reg <= capture ? ch_onehot : '0;
            done_reg     <= done_set;

            if (fail_set) begin
                fail_reg <= 1'b1;
            end else if (fail_clr) begin
                fail_reg <= 1'b0;
            end
        end
    end

    assign adc.adc_start    = (state_reg == START);
    assign adc.adc_ch       = ch_reg;
    assign ch_data_valid    = ch_valid_reg;
    assign ch_data_value    = data_reg;
    assign scan_done        = done_reg;
    assign adc_timeout_fail = fail_reg;

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Scoreboard bench for adc_scan_scheduler: an ADC responder pushes expected results,
// a monitor pops and compares on every adc_start / ch_data_valid.
`timescale 1ns/1ps
module tb_adc_scan_scheduler;
    localparam int NUM_CH      = 4;
    localparam int CH_W        = 2;
    localparam int DATA_W      = 16;
    localparam int TIMEOUT_CYC = 1024;
    localparam int TMO_W       = 11;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b0;
    logic              clear_timeout_fail = 1'b0;
    logic [NUM_CH-1:0] ch_enable_mask = '0;
    logic [15:0]       scan_interval = '0;
    logic [NUM_CH-1:0] ch_data_valid;
    logic [DATA_W-1:0] ch_data_value;
    logic              scan_done;
    logic              adc_timeout_fail;

    adc_scan_if #(.CH_W(CH_W), .DATA_W(DATA_W)) bus ();

    logic              resp_valid  = 1'b0;
    logic              stray_valid = 1'b0;
    logic [DATA_W-1:0] resp_value  = '0;
    logic [DATA_W-1:0] stray_value = '0;
    assign bus.adc_data_valid = resp_valid | stray_valid;
    assign bus.adc_data_value = stray_valid ? stray_value : resp_value;

    always #5 clk = ~clk;

    adc_scan_scheduler #(
        .NUM_CH(NUM_CH), .CH_W(CH_W), .DATA_W(DATA_W),
        .TIMEOUT_CYC(TIMEOUT_CYC), .TMO_W(TMO_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .ch_enable_mask(ch_enable_mask),
        .scan_interval(scan_interval),
        .adc(bus),
        .ch_data_valid(ch_data_valid),
        .ch_data_value(ch_data_value),
        .scan_done(scan_done),
        .adc_timeout_fail(adc_timeout_fail),
        .clear_timeout_fail(clear_timeout_fail)
    );

    typedef struct {
        logic [NUM_CH-1:0] onehot;
        logic [DATA_W-1:0] value;
    } res_t;

    res_t              exp_q[$];
    logic [CH_W-1:0]   exp_ch_q[$];
    int                start_cyc_q[$];
    int                n_vec = 0;
    int                n_err = 0;
    int                done_cnt = 0;
    int                cyc = 0;
    logic [DATA_W-1:0] last_value = '0;
    int                resp_delay = 0;   // 0 -> random 1..8 cycles
    bit                resp_silent = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: every convert request and every result strobe is matched against the queues.
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            if (bus.adc_start) begin
                if (exp_ch_q.size() == 0) check("unexpected_adc_start", 64'(bus.adc_start), 64'd0);
                else check("adc_ch", 64'(bus.adc_ch), 64'(exp_ch_q.pop_front()));
                start_cyc_q.push_back(cyc);
            end
            if (ch_data_valid != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ch_data_valid", 64'(ch_data_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("ch_data_valid", 64'(ch_data_valid), 64'(e.onehot));
                    check("ch_data_value", 64'(ch_data_value), 64'(e.value));
                    last_value = e.value;
                end
            end
            if (scan_done) done_cnt++;
        end
    end

    // ADC model: answers each request after a delay with a random value.
    initial begin
        int              d;
        logic [CH_W-1:0] ch;
        res_t            r;
        forever begin
            @(negedge clk);
            if (bus.adc_start && !resp_silent) begin
                ch = bus.adc_ch;
                d  = (resp_delay == 0) ? int'($urandom_range(1, 8)) : resp_delay;
                repeat (d) @(negedge clk);
                r.onehot     = '0;
                r.onehot[ch] = 1'b1;
                r.value      = DATA_W'($urandom);
                exp_q.push_back(r);
                resp_value = r.value;
                resp_valid = 1'b1;
                @(negedge clk);
                resp_valid = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_scan(input logic [NUM_CH-1:0] m);
        for (int i = 0; i < NUM_CH; i++) if (m[i]) exp_ch_q.push_back(CH_W'(i));
    endtask

    task automatic wait_start(input int budget);
        int c;
        c = 0;
        while (c < budget && !bus.adc_start) begin
            @(negedge clk);
            c++;
        end
        check("adc_start_seen", 64'(bus.adc_start), 64'd1);
    endtask

    // Waits for k scan_done pulses; unless hold, drops enable in the same cycle as the last.
    task automatic run_scans(input int k, input int budget, input bit hold);
        int seen;
        seen = 0;
        for (int c = 0; c < budget && seen < k; c++) begin
            @(negedge clk);
            if (scan_done) seen++;
        end
        if (!hold) enable = 1'b0;
        check("scans_completed", 64'(seen), 64'(k));
    endtask

    task automatic drain();
        tick(30);
        check("exp_ch_q_empty", 64'(exp_ch_q.size()), 64'd0);
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int                d0;
        int                k;
        int                n;
        logic [NUM_CH-1:0] m;

        // Reset state
        tick(3);
        check("reset_outputs", {39'd0, bus.adc_start, bus.adc_ch, ch_data_valid, ch_data_value,
              scan_done, adc_timeout_fail}, 64'd0);
        rst = 1'b0;
        tick(2);
        check("idle_outputs", {39'd0, bus.adc_start, bus.adc_ch, ch_data_valid, ch_data_value,
              scan_done, adc_timeout_fail}, 64'd0);

        // 1: mask 1011, interval 200, ADC answers after 5 cycles, two scans
        ch_enable_mask = 4'b1011; scan_interval = 16'd200; resp_delay = 5;
        push_scan(4'b1011); push_scan(4'b1011);
        start_cyc_q.delete(); d0 = done_cnt;
        enable = 1'b1;
        run_scans(2, 1000, 1'b0);
        drain();
        check("t1_start_count", 64'(start_cyc_q.size()), 64'd6);
        if (start_cyc_q.size() >= 4) check("t1_interval", 64'(start_cyc_q[3] - start_cyc_q[0]), 64'd200);
        check("t1_scan_done_count", 64'(done_cnt - d0), 64'd2);

        // 2: ADC silent -> timeout fault, then clear and rescan
        ch_enable_mask = 4'b0100; scan_interval = 16'd50; resp_silent = 1'b1;
        push_scan(4'b0100);
        enable = 1'b1;
        wait_start(20);
        tick(TIMEOUT_CYC);
        check("t2_fail_before_timeout", 64'(adc_timeout_fail), 64'd0);
        tick(1);
        check("t2_fail_at_timeout", 64'(adc_timeout_fail), 64'd1);
        tick(1500);
        check("t2_fail_sticky", 64'(adc_timeout_fail), 64'd1);
        resp_silent = 1'b0; resp_delay = 5;
        push_scan(4'b0100);
        clear_timeout_fail = 1'b1;
        tick(1);
        clear_timeout_fail = 1'b0;
        check("t2_fail_cleared", 64'(adc_timeout_fail), 64'd0);
        run_scans(1, 200, 1'b0);
        drain();

        // 3: result arrives on the very last timeout cycle
        ch_enable_mask = 4'b0001; scan_interval = 16'd2000; resp_delay = TIMEOUT_CYC;
        push_scan(4'b0001);
        enable = 1'b1;
        run_scans(1, 1200, 1'b0);
        check("t3_no_fault", 64'(adc_timeout_fail), 64'd0);
        drain();

        // 4: mask shrinks mid-scan; current scan completes, next uses new mask
        ch_enable_mask = 4'b1111; scan_interval = 16'd300; resp_delay = 3;
        push_scan(4'b1111); push_scan(4'b0001);
        enable = 1'b1;
        wait_start(20);
        ch_enable_mask = 4'b0001;
        run_scans(2, 1000, 1'b0);
        drain();

        // 5: enable dropped during CONVERT
        ch_enable_mask = 4'b0011; scan_interval = 16'd100; resp_delay = 20;
        exp_ch_q.push_back(2'd0);
        d0 = done_cnt;
        enable = 1'b1;
        wait_start(20);
        tick(5);
        enable = 1'b0;
        tick(40);
        drain();
        check("t5_no_scan_done", 64'(done_cnt - d0), 64'd0);

        // 6a: stray ADC strobe during WAIT_IVL
        ch_enable_mask = 4'b0010; scan_interval = 16'd300; resp_delay = 4;
        push_scan(4'b0010);
        enable = 1'b1;
        run_scans(1, 200, 1'b1);
        tick(3);
        stray_value = ~last_value;
        stray_valid = 1'b1;
        tick(1);
        stray_valid = 1'b0;
        check("t6_stray_no_strobe", 64'(ch_data_valid), 64'd0);
        check("t6_stray_value_held", 64'(ch_data_value), 64'(last_value));
        enable = 1'b0;
        drain();

        // 6b: reset asserted mid-CONVERT
        resp_silent = 1'b1;
        push_scan(4'b0010);
        enable = 1'b1;
        wait_start(20);
        tick(3);
        rst = 1'b1;
        tick(1);
        check("t6_rst_outputs", {39'd0, bus.adc_start, bus.adc_ch, ch_data_valid, ch_data_value,
              scan_done, adc_timeout_fail}, 64'd0);
        enable = 1'b0;
        rst = 1'b0;
        last_value = '0;
        resp_silent = 1'b0;
        drain();

        // Randomised scans
        for (int it = 0; it < 8; it++) begin
            m = NUM_CH'($urandom_range(1, 15));
            ch_enable_mask = m;
            scan_interval = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom_range(80, 200));
            resp_delay = 0;
            k = int'($urandom_range(1, 3));
            n = $countones(m);
            for (int s = 0; s < k; s++) push_scan(m);
            start_cyc_q.delete(); d0 = done_cnt;
            enable = 1'b1;
            run_scans(k, 2000, 1'b0);
            drain();
            check("rand_start_count", 64'(start_cyc_q.size()), 64'(n * k));
            check("rand_scan_done_count", 64'(done_cnt - d0), 64'(k));
            if (scan_interval != 16'd0 && start_cyc_q.size() > n)
                check("rand_interval", 64'(start_cyc_q[n] - start_cyc_q[0]), 64'(scan_interval));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
